// File: rtl/lin_class_pipe.sv
// Streaming linear classifier: sum_k w[k]*x[k] + bias, saturated to ACC_W.
// Weights and bias are captured with each sample, so a config write never affects samples already in flight.
module lin_class_lane #(
    parameter int IN_W  = 6,
    parameter int WGT_W = 6,
    parameter int PW    = IN_W + WGT_W + 1
) (
    input  logic                 clk,
    input  logic                 take,
    input  logic                 mul_en,
    input  logic [IN_W-1:0]      x,
    input  logic [WGT_W-1:0]     w,
    output logic signed [PW-1:0] prod
);
    logic [IN_W-1:0]  x_q;
    logic [WGT_W-1:0] w_q;
    logic signed [PW-1:0] xs, ws;

    // x is unsigned, so it is zero-extended before the signed multiply
    assign xs = PW'($signed({1'b0, x_q}));
    assign ws = PW'($signed(w_q));

    always_ff @(posedge clk) begin
        if (take) begin
            x_q <= x;
            w_q <= w;
        end
        if (mul_en) prod <= xs * ws;
    end
endmodule

module lin_class_pipe #(
    parameter int N_CH   = 3,
    parameter int IN_W   = 6,
    parameter int WGT_W  = 6,
    parameter int BIAS_W = 10,
    parameter int ACC_W  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    input  logic [N_CH*IN_W-1:0]    i_im,
    input  logic                    i_cfg_we,
    input  logic [3:0]              i_cfg_addr,
    input  logic [15:0]             i_cfg_data,
    output logic                    o_valid,
    output logic signed [ACC_W-1:0] o_wgt_sum,
    output logic                    o_pos,
    output logic                    o_sat
);
    localparam int STAGES = 3;
    localparam int PW = IN_W + WGT_W + 1;
    localparam int IW = PW + $clog2(N_CH) + 1;
    localparam int TW = (IW > ACC_W) ? IW : ACC_W;
    localparam logic signed [TW-1:0] SAT_MAX = {{(TW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [TW-1:0] SAT_MIN = {{(TW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef struct packed {
        logic signed [ACC_W-1:0] sum;
        logic                    pos;
        logic                    sat;
    } result_t;

    function automatic logic [WGT_W-1:0] wgt_default(input int k);
        case (k)
            0:       return WGT_W'(5);
            1:       return WGT_W'(1);
            2:       return WGT_W'(-9);
            default: return '0;
        endcase
    endfunction

    logic [N_CH-1:0][WGT_W-1:0] wgt;
    logic [BIAS_W-1:0]          bias;
    logic [STAGES:0]            vld_pipe;
    logic                       take;
    logic [N_CH-1:0][PW-1:0]    prod;
    logic [BIAS_W-1:0]          bias_s0, bias_s1, bias_s2;
    logic signed [IW-1:0]       tree, sum_s2, total;
    logic signed [TW-1:0]       total_x;
    result_t                    res;
    logic                       cfg_unused;

    assign cfg_unused = ^i_cfg_data;
    assign take       = i_valid & ~i_rst;
    assign o_valid    = vld_pipe[STAGES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N_CH; k++) wgt[k] <= wgt_default(k);
            bias <= BIAS_W'(-76);
        end else if (i_cfg_we) begin
            for (int k = 0; k < N_CH; k++)
                if (i_cfg_addr == 4'(k)) wgt[k] <= i_cfg_data[WGT_W-1:0];
            if (i_cfg_addr == 4'hF) bias <= i_cfg_data[BIAS_W-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-1:0], i_valid};
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        lin_class_lane #(.IN_W(IN_W), .WGT_W(WGT_W), .PW(PW)) u_lane (
            .clk    (i_clk),
            .take   (take),
            .mul_en (vld_pipe[0]),
            .x      (i_im[k*IN_W +: IN_W]),
            .w      (wgt[k]),
            .prod   (prod[k])
        );
    end

    always_comb begin
        tree = '0;
        for (int k = 0; k < N_CH; k++) tree = tree + IW'($signed(prod[k]));
    end

    // bias rides alongside the products so it matches the weights of the same sample
    always_ff @(posedge i_clk) begin
        if (take) bias_s0 <= bias;
        if (vld_pipe[0]) bias_s1 <= bias_s0;
        if (vld_pipe[1]) begin
            bias_s2 <= bias_s1;
            sum_s2  <= tree;
        end
    end

    always_comb begin
        total   = sum_s2 + IW'($signed(bias_s2));
        total_x = TW'(total);
        res.sat = 1'b1;
        if (total_x > SAT_MAX)      res.sum = SAT_MAX[ACC_W-1:0];
        else if (total_x < SAT_MIN) res.sum = SAT_MIN[ACC_W-1:0];
        else begin
            res.sum = total_x[ACC_W-1:0];
            res.sat = 1'b0;
        end
        res.pos = ~res.sum[ACC_W-1];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wgt_sum <= '0;
            o_pos     <= 1'b1;
            o_sat     <= 1'b0;
        end else if (vld_pipe[2]) begin
            o_wgt_sum <= res.sum;
            o_pos     <= res.pos;
            o_sat     <= res.sat;
        end
    end
endmodule

// File: tb/tb_lin_class_pipe.sv
// Directed bench for lin_class_pipe: default build plus an ACC_W=10 build for saturation.
module tb_lin_class_pipe;
    localparam int N_CH = 3;
    localparam int IN_W = 6;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic                   i_rst, i_valid, i_cfg_we;
    logic [N_CH*IN_W-1:0]   i_im;
    logic [3:0]             i_cfg_addr;
    logic [15:0]            i_cfg_data;
    logic                   o_valid, o_pos, o_sat;
    logic signed [15:0]     o_wgt_sum;
    logic                   v10, p10, s10;
    logic signed [9:0]      w10;

    int checks = 0;
    int errors = 0;

    lin_class_pipe dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_im(i_im),
        .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
        .o_valid(o_valid), .o_wgt_sum(o_wgt_sum), .o_pos(o_pos), .o_sat(o_sat)
    );

    lin_class_pipe #(.ACC_W(10)) dut10 (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_im(i_im),
        .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data),
        .o_valid(v10), .o_wgt_sum(w10), .o_pos(p10), .o_sat(s10)
    );

    typedef struct {
        int a; int b; int c;
        int e16; int e10; bit sat10;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [N_CH*IN_W-1:0] pk(input int a, input int b, input int c);
        return {6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic chk_out(input string name, input int e16, input int e10, input bit sat10);
        chk({name, " valid"}, o_valid, 1);
        chk({name, " sum"}, o_wgt_sum, e16);
        chk({name, " pos"}, o_pos, e16 >= 0);
        chk({name, " sat"}, o_sat, 0);
        chk({name, " valid10"}, v10, 1);
        chk({name, " sum10"}, w10, e10);
        chk({name, " pos10"}, p10, e10 >= 0);
        chk({name, " sat10"}, s10, sat10);
    endtask

    task automatic chk_rst(input string name);
        chk({name, " valid"}, o_valid, 0);
        chk({name, " sum"}, o_wgt_sum, 0);
        chk({name, " pos"}, o_pos, 1);
        chk({name, " sat"}, o_sat, 0);
        chk({name, " valid10"}, v10, 0);
        chk({name, " sum10"}, w10, 0);
    endtask

    task automatic cfg(input logic [3:0] a, input logic [15:0] d);
        @(negedge i_clk);
        i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_data = d;
        @(negedge i_clk);
        i_cfg_we = 1'b0;
    endtask

    // one sample: output expected right after the fourth rising edge
    task automatic run_one(input string name, input int a, input int b, input int c,
                           input int e16, input int e10, input bit sat10, input bit release_rst);
        @(negedge i_clk);
        if (release_rst) i_rst = 1'b0;
        i_valid = 1'b1; i_im = pk(a, b, c);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (2) begin
            @(negedge i_clk);
            chk({name, " early"}, o_valid, 0);
        end
        @(negedge i_clk);
        chk_out(name, e16, e10, sat10);
        @(negedge i_clk);
        chk({name, " drop"}, o_valid, 0);
        chk({name, " hold"}, o_wgt_sum, e16);
    endtask

    initial begin
        i_rst = 1'b1; i_valid = 1'b0; i_cfg_we = 1'b0;
        i_cfg_addr = '0; i_cfg_data = '0; i_im = '0;

        vecs[0] = '{0, 0, 0, -76, -76, 0};
        vecs[1] = '{63, 63, 0, 302, 302, 0};
        vecs[2] = '{0, 0, 63, -643, -512, 1};
        vecs[3] = '{1, 1, 1, -79, -79, 0};
        vecs[4] = '{15, 0, 0, -1, -1, 0};
        vecs[5] = '{15, 1, 0, 0, 0, 0};
        vecs[6] = '{63, 63, 63, -265, -265, 0};
        vecs[7] = '{0, 0, 48, -508, -508, 0};
        vecs[8] = '{1, 0, 49, -512, -512, 0};
        vecs[9] = '{0, 0, 49, -517, -512, 1};

        repeat (3) @(negedge i_clk);
        chk_rst("reset");

        // first vector is sent on the edge that releases reset
        for (int i = 0; i < 10; i++)
            run_one($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c,
                    vecs[i].e16, vecs[i].e10, vecs[i].sat10, i == 0);

        cfg(4'd7, 16'h7FFF);
        cfg(4'd3, 16'h1234);
        run_one("unmapped", 1, 1, 1, -79, -79, 0, 0);

        @(negedge i_clk); i_valid = 1'b1; i_im = pk(63, 63, 0);
        @(negedge i_clk); i_im = pk(0, 0, 63);
        @(negedge i_clk); i_valid = 1'b0;
        @(negedge i_clk); chk("b2b early", o_valid, 0);
        @(negedge i_clk); chk_out("b2b first", 302, 302, 0);
        @(negedge i_clk); chk_out("b2b second", -643, -512, 1);
        @(negedge i_clk); chk("b2b drop", o_valid, 0);

        @(negedge i_clk);
        i_cfg_we = 1'b1; i_cfg_addr = 4'd2; i_cfg_data = 16'h0009;
        i_valid = 1'b1; i_im = pk(0, 0, 10);
        @(negedge i_clk); i_cfg_we = 1'b0;
        @(negedge i_clk); i_valid = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk); chk_out("wr same", -166, -166, 0);
        @(negedge i_clk); chk_out("wr next", 14, 14, 0);

        cfg(4'd0, 16'h001F);
        cfg(4'd1, 16'h001F);
        cfg(4'd15, 16'h01FF);
        run_one("sat hi", 63, 63, 0, 4417, 511, 1, 0);
        cfg(4'd2, 16'hFFE0);
        cfg(4'd15, 16'hFE00);
        run_one("sat lo", 0, 0, 63, -2528, -512, 1, 0);

        // three samples in flight, then reset together with a write and a valid
        @(negedge i_clk); i_valid = 1'b1; i_im = pk(63, 63, 0);
        @(negedge i_clk); i_im = pk(0, 0, 63);
        @(negedge i_clk); i_im = pk(1, 1, 1);
        @(negedge i_clk);
        i_rst = 1'b1; i_cfg_we = 1'b1; i_cfg_addr = 4'd0; i_cfg_data = 16'h0000;
        i_im = pk(63, 63, 0);
        @(negedge i_clk);
        i_rst = 1'b0; i_cfg_we = 1'b0; i_valid = 1'b0;
        chk_rst("mid rst");
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk($sformatf("mid rst quiet%0d", i), o_valid, 0);
            chk($sformatf("mid rst quiet10 %0d", i), v10, 0);
        end
        run_one("post rst w", 1, 1, 1, -79, -79, 0, 0);
        run_one("post rst b", 0, 0, 0, -76, -76, 0, 0);
        run_one("post rst w2", 0, 0, 63, -643, -512, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lin_class_pipe.md
LIN_CLASS_PIPE -- requirements
Module: lin_class_pipe

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter N_CH, default 3: number of input channels, legal range 1..8.
REQ-003 Parameter IN_W, default 6: unsigned input sample width, legal range 2..12.
REQ-004 Parameter WGT_W, default 6: signed two's-complement weight width.
REQ-005 Parameter BIAS_W, default 10: signed two's-complement bias width.
REQ-006 Parameter ACC_W, default 16: signed output width, minimum 8.
REQ-007 Port i_clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-008 Port i_rst, input, 1 bit: synchronous active-high reset.
REQ-009 Port i_valid, input, 1 bit: i_im holds a sample this cycle.
REQ-010 Port i_im, input, N_CH*IN_W bits: packed unsigned samples; channel k occupies bits [k*IN_W +: IN_W].
REQ-011 Port i_cfg_we, input, 1 bit: write enable for a weight or the bias.
REQ-012 Port i_cfg_addr, input, 4 bits: address 0..N_CH-1 selects weight k; address 15 selects the bias; all other addresses are ignored.
REQ-013 Port i_cfg_data, input, 16 bits: write data; the low WGT_W bits are used for a weight and the low BIAS_W bits for the bias.
REQ-014 Port o_valid, output, 1 bit: o_wgt_sum, o_pos and o_sat are valid this cycle.
REQ-015 Port o_wgt_sum, output, ACC_W bits: signed sum of w[k]*x[k] over all channels, plus the bias.
REQ-016 Port o_pos, output, 1 bit: 1 when o_wgt_sum >= 0.
REQ-017 Port o_sat, output, 1 bit: 1 when the exact sum was clamped to fit ACC_W.

Function
REQ-018 The block SHALL be a three-stage pipeline with a fixed latency of 3: a sample accepted at edge t appears with o_valid=1 after edge t+3.
- Stage 1: one signed product per channel, full precision.
- Stage 2: adder tree over all products.
- Stage 3: bias add, saturation, output register.
REQ-019 The block SHALL accept one sample per cycle with no stall; back-to-back i_valid SHALL produce back-to-back o_valid.
REQ-020 A valid bit SHALL travel with each stage; stages holding no valid sample SHALL NOT update that stage's data registers.
REQ-021 o_wgt_sum, o_pos and o_sat SHALL hold their last values while o_valid=0.
REQ-022 Internal arithmetic SHALL be exact.
- Internal width = IN_W + WGT_W + 1 + ceil(log2(N_CH)) + 1 bits.
- The bias is sign-extended before it is added.
REQ-023 If the exact sum is greater than 2^(ACC_W-1)-1, the output SHALL be that maximum and o_sat=1.
REQ-024 If the exact sum is less than -2^(ACC_W-1), the output SHALL be that minimum and o_sat=1.
REQ-025 Otherwise the output SHALL be the exact sum and o_sat=0.
REQ-026 o_pos SHALL equal the inverse of the sign bit of the (possibly saturated) o_wgt_sum.
REQ-027 A configuration write at edge t SHALL be used by samples accepted at edge t+1 or later.
REQ-028 A sample accepted at edge t, including one accepted in the same cycle as a write, SHALL use the configuration in force before edge t.
REQ-029 Weights and bias SHALL be sampled into stage 1 together with the sample, so a write never affects samples already in flight.
REQ-030 A write to an unmapped address SHALL have no effect.
REQ-031 i_cfg_we and i_valid SHALL be honoured in any combination, including both at once.

Reset
REQ-032 While i_rst=1 at an edge, all valid bits SHALL clear and no o_valid SHALL be produced for samples in flight; this includes reset asserted mid-pipeline.
REQ-033 Reset values:
- o_valid=0, o_wgt_sum=0, o_pos=1, o_sat=0.
- w[0]=5, w[1]=1, w[2]=-9, remaining weights 0 (only those channels that exist).
- bias=-76.
REQ-034 Reset SHALL take priority over i_valid and i_cfg_we in the same cycle.
REQ-035 The first sample SHALL be accepted at the first edge with i_rst=0.

Verification
REQ-036 Defaults, i_im=(x0,x1,x2)=(0,0,0), one valid -> 3 cycles later o_valid=1 for 1 cycle, o_wgt_sum=-76, o_pos=0, o_sat=0.
REQ-037 Defaults, back-to-back samples (63,63,0) then (0,0,63) -> consecutive outputs 302 (o_pos=1), then -643 (o_pos=0); no o_valid gaps.
REQ-038 Write w[2]=+9 and send (0,0,10) in the same cycle -> result -166; the next sample (0,0,10) -> 14.
REQ-039 Build with ACC_W=10, send (0,0,63) with defaults -> o_wgt_sum=-512, o_sat=1; send (63,63,0) -> 302, o_sat=0.
REQ-040 Three valid samples, then i_rst=1 for 1 cycle while they are in flight -> no o_valid for them; weights and bias return to their defaults.
REQ-041 Write to address 7 with N_CH=3, then send (1,1,1) -> -79; configuration unchanged.
